data_memory_arbiter: RTL and testbench
======================================

Name: data_memory_arbiter

Overview:
Shares the single-port data memory between the CPU datapath (load/store/ALU-operand accesses issued by control) and an external requester (program loader / debug port).
- CPU has default priority.
- A starvation counter guarantees the external side a grant within a bounded number of cycles.
- Sits between control/datapath and the data memory, and stalls the CPU when it loses arbitration.

Parameters:
DATA_WIDTH, 16, memory word width.
OPERAND_WIDTH, 11, data-memory address width (matches instruction operand field).
STARVE_LIMIT, 4, consecutive denied external cycles before the external side is forced a grant; legal range 1..15.

Ports:
clock_in  input  1  system clock, rising edge.
reset_in  input  1  asynchronous, active-high reset.
cpu_req_in  input  1  CPU requests memory access this cycle.
cpu_wr_in  input  1  1=write, 0=read.
cpu_address_in  input  OPERAND_WIDTH  CPU address.
cpu_data_in  input  DATA_WIDTH  CPU write data.
cpu_stall_out  output  1  CPU request not served this cycle; control holds PC/instruction.
cpu_data_out  output  DATA_WIDTH  read data returned to CPU.
cpu_valid_out  output  1  cpu_data_out valid (one-cycle pulse).
ext_req_in  input  1  external request; held until granted.
ext_wr_in  input  1  1=write, 0=read.
ext_address_in  input  OPERAND_WIDTH  external address.
ext_data_in  input  DATA_WIDTH  external write data.
ext_lock_in  input  1  burst lock (used only with the optional feature).
ext_gnt_out  output  1  external request accepted this cycle.
ext_data_out  output  DATA_WIDTH  read data returned to external side.
ext_valid_out  output  1  ext_data_out valid (one-cycle pulse).
mem_address_out  output  OPERAND_WIDTH  memory address.
mem_data_out  output  DATA_WIDTH  memory write data.
mem_wr_out  output  1  memory write enable.
mem_data_in  input  DATA_WIDTH  memory read data; synchronous read, one-cycle latency.

Behaviour:
- Reset (async, any time, including mid-burst or with a read in flight):
  - state=ARB_CPU, starve count=0, read owner=OWN_NONE.
  - All *_valid_out, ext_gnt_out, mem_wr_out=0.
  - In-flight read response is dropped.
- Arbitration is combinational per cycle from requests, state and starve count. At most one requester is granted per cycle.
- State ARB_CPU:
  - Only cpu_req → CPU granted.
  - Only ext_req → ext granted, count cleared.
  - Both, count<STARVE_LIMIT → CPU granted, count+1.
  - Both, count==STARVE_LIMIT → ext granted, count cleared, cpu_stall_out=1.
- cpu_stall_out = cpu_req_in & ~cpu_granted. A stalled CPU re-presents the same request; nothing is lost.
- Ext handshake:
  - ext_gnt_out=1 for exactly the grant cycle.
  - Address, data and wr are sampled at that cycle.
  - ext_req_in high with unchanged fields after a grant is a new request.
- Memory drive:
  - Granted requester's address/data go to mem_*.
  - mem_wr_out = granted & wr.
  - With no grant: mem_address_out=cpu_address_in, mem_wr_out=0.
- Read return:
  - A granted read sets read owner (registered).
  - Next cycle the owner's valid_out=1 and its data_out=mem_data_in. The other side's data_out holds 0.
  - Writes produce no valid pulse.
  - Back-to-back reads give back-to-back valid pulses.
- Count saturates at STARVE_LIMIT and clears whenever ext_req_in=0.

Optional Feature:
Macro ARBITER_BURST_LOCK_EN.
- Defined:
  - An ext grant with ext_lock_in=1 moves the FSM to ARB_EXT_LOCK.
  - In ARB_EXT_LOCK, ext is granted every cycle ext_req_in=1, and the CPU is stalled whenever cpu_req_in=1.
  - Count is frozen at 0.
  - Returns to ARB_CPU in the cycle after ext_lock_in=0 or ext_req_in=0 is seen.
- Not defined: ext_lock_in is ignored, ARB_EXT_LOCK is unreachable, and the port remains.

Decomposition:
- Package arbiter_pkg holds:
  - owner_t enum {OWN_NONE, OWN_CPU, OWN_EXT}.
  - arb_state_t enum {ARB_CPU, ARB_EXT_LOCK}.
  - Constant STARVE_COUNT_WIDTH=4.
- One sub-module, starve_counter: inputs increment, clear and freeze, plus reset. Outputs the count and a limit_reached flag.

Test Plan:
- Reset held, then released with cpu_req=1, rd, addr 0x00D → mem_address_out=0x00D, no stall; next cycle cpu_valid_out=1, cpu_data_out=mem_data_in.
- cpu_req and ext_req held high continuously, STARVE_LIMIT=4 → CPU granted 4 cycles, 5th cycle ext_gnt_out=1 and cpu_stall_out=1, then the pattern repeats.
- ext write 0x0ABC to 0x005 with CPU idle → ext_gnt_out same cycle, mem_wr_out=1, mem_data_out=0x0ABC, no valid pulse.
- ext read granted, then reset_in asserted in the next cycle before the return → ext_valid_out stays 0, all outputs at reset values.
- Alternating CPU read / ext read on consecutive cycles → cpu_valid_out and ext_valid_out pulse on alternating cycles, with data routed to the correct side.
- With ARBITER_BURST_LOCK_EN: ext grant with lock=1 for 3 cycles while cpu_req=1 → 3 ext grants and 3 stall cycles; lock drops → CPU granted the following cycle. Without the macro, the same stimulus gives the normal starvation pattern.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared types for the data-memory arbiter.
// Holds read-owner and arbitration-state enums plus the starve counter width.
package arbiter_pkg;
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_EXT
  } owner_t;

  typedef enum logic {
    ARB_CPU,
    ARB_EXT_LOCK
  } arb_state_t;

  localparam int STARVE_COUNT_WIDTH = 4;
endpackage

// File: rtl/data_memory_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the external side was denied.
// Clear wins over freeze, freeze wins over increment.
module starve_counter
  import arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          increment,
  input  logic                          clear,
  input  logic                          freeze,
  output logic [STARVE_COUNT_WIDTH-1:0] count,
  output logic                          limit_reached
);
  localparam logic [STARVE_COUNT_WIDTH-1:0] LIM =
    STARVE_COUNT_WIDTH'(LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (freeze) begin
      count <= count;
    end else if (increment && (count != LIM)) begin
      count <= count + 1'b1;
    end
  end

  assign limit_reached = (count == LIM);
endmodule

// File: rtl/data_memory_arbiter.sv
// Single-port data memory arbiter: CPU priority with starvation guard.
// Optional burst lock for the external side under ARBITER_BURST_LOCK_EN.
module data_memory_arbiter
  import arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int OPERAND_WIDTH = 11,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     cpu_req_in,
  input  logic                     cpu_wr_in,
  input  logic [OPERAND_WIDTH-1:0] cpu_address_in,
  input  logic [DATA_WIDTH-1:0]    cpu_data_in,
  output logic                     cpu_stall_out,
  output logic [DATA_WIDTH-1:0]    cpu_data_out,
  output logic                     cpu_valid_out,
  input  logic                     ext_req_in,
  input  logic                     ext_wr_in,
  input  logic [OPERAND_WIDTH-1:0] ext_address_in,
  input  logic [DATA_WIDTH-1:0]    ext_data_in,
  input  logic                     ext_lock_in,
  output logic                     ext_gnt_out,
  output logic [DATA_WIDTH-1:0]    ext_data_out,
  output logic                     ext_valid_out,
  output logic [OPERAND_WIDTH-1:0] mem_address_out,
  output logic [DATA_WIDTH-1:0]    mem_data_out,
  output logic                     mem_wr_out,
  input  logic [DATA_WIDTH-1:0]    mem_data_in
);
  arb_state_t state, next_state;
  owner_t     owner;
  logic       cpu_gnt, ext_gnt;
  logic       increment, clear, freeze;
  logic       limit_reached;
  logic [STARVE_COUNT_WIDTH-1:0] count;

  starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk          (clock_in),
    .rst          (reset_in),
    .increment    (increment),
    .clear        (clear),
    .freeze       (freeze),
    .count        (count),
    .limit_reached(limit_reached)
  );

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state <= ARB_CPU;
      owner <= OWN_NONE;
    end else begin
      state <= next_state;
      if (cpu_gnt && !cpu_wr_in) begin
        owner <= OWN_CPU;
      end else if (ext_gnt && !ext_wr_in) begin
        owner <= OWN_EXT;
      end else begin
        owner <= OWN_NONE;
      end
    end
  end

  always_comb begin
    cpu_gnt    = 1'b0;
    ext_gnt    = 1'b0;
    increment  = 1'b0;
    next_state = state;
    unique case (state)
      ARB_CPU: begin
        if (cpu_req_in && ext_req_in) begin
          if (limit_reached) begin
            ext_gnt = 1'b1;
          end else begin
            cpu_gnt   = 1'b1;
            increment = 1'b1;
          end
        end else if (cpu_req_in) begin
          cpu_gnt = 1'b1;
        end else if (ext_req_in) begin
          ext_gnt = 1'b1;
        end
`ifdef ARBITER_BURST_LOCK_EN
        if (ext_gnt && ext_lock_in) begin
          next_state = ARB_EXT_LOCK;
        end
`endif
      end
      ARB_EXT_LOCK: begin
        // CPU is held off for the whole burst, even on its last cycle
        ext_gnt = ext_req_in;
        if (!ext_req_in || !ext_lock_in) begin
          next_state = ARB_CPU;
        end
      end
      default: next_state = ARB_CPU;
    endcase
    if (reset_in) begin
      cpu_gnt   = 1'b0;
      ext_gnt   = 1'b0;
      increment = 1'b0;
    end
  end

  assign clear  = !ext_req_in || ext_gnt;
  assign freeze = (state == ARB_EXT_LOCK);

  assign cpu_stall_out = cpu_req_in && !cpu_gnt;
  assign ext_gnt_out   = ext_gnt;

  assign mem_address_out = ext_gnt ? ext_address_in : cpu_address_in;
  assign mem_data_out    = ext_gnt ? ext_data_in : cpu_data_in;
  assign mem_wr_out      = (cpu_gnt && cpu_wr_in) ||
                           (ext_gnt && ext_wr_in);

  assign cpu_valid_out = (owner == OWN_CPU);
  assign ext_valid_out = (owner == OWN_EXT);
  assign cpu_data_out  = cpu_valid_out ? mem_data_in : '0;
  assign ext_data_out  = ext_valid_out ? mem_data_in : '0;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomized self-checking bench for data_memory_arbiter.
// Reference model tracks ext wait streak, lock and pending read owner.
module tb_data_memory_arbiter;
  localparam int DW = 16;
  localparam int AW = 11;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset_in;
  logic cpu_req_in, cpu_wr_in;
  logic [AW-1:0] cpu_address_in;
  logic [DW-1:0] cpu_data_in;
  logic cpu_stall_out, cpu_valid_out;
  logic [DW-1:0] cpu_data_out;
  logic ext_req_in, ext_wr_in, ext_lock_in;
  logic [AW-1:0] ext_address_in;
  logic [DW-1:0] ext_data_in;
  logic ext_gnt_out, ext_valid_out;
  logic [DW-1:0] ext_data_out;
  logic [AW-1:0] mem_address_out;
  logic [DW-1:0] mem_data_out;
  logic mem_wr_out;
  logic [DW-1:0] mem_data_in;

  int checks = 0;
  int fails = 0;
  int cyc = 0;

  // model state: wait streak, burst lock, pending read (0 none,1 cpu,2 ext)
  int m_wait = 0;
  bit m_locked = 0;
  int m_owner = 0;
  logic [63:0] exp;

  wire [63:0] obs = {cpu_stall_out, ext_gnt_out, mem_wr_out,
                     cpu_valid_out, ext_valid_out, mem_address_out,
                     mem_data_out, cpu_data_out, ext_data_out};

  always #5 clk = ~clk;

  data_memory_arbiter #(
    .DATA_WIDTH(DW),
    .OPERAND_WIDTH(AW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clock_in(clk),
    .reset_in(reset_in),
    .cpu_req_in(cpu_req_in),
    .cpu_wr_in(cpu_wr_in),
    .cpu_address_in(cpu_address_in),
    .cpu_data_in(cpu_data_in),
    .cpu_stall_out(cpu_stall_out),
    .cpu_data_out(cpu_data_out),
    .cpu_valid_out(cpu_valid_out),
    .ext_req_in(ext_req_in),
    .ext_wr_in(ext_wr_in),
    .ext_address_in(ext_address_in),
    .ext_data_in(ext_data_in),
    .ext_lock_in(ext_lock_in),
    .ext_gnt_out(ext_gnt_out),
    .ext_data_out(ext_data_out),
    .ext_valid_out(ext_valid_out),
    .mem_address_out(mem_address_out),
    .mem_data_out(mem_data_out),
    .mem_wr_out(mem_wr_out),
    .mem_data_in(mem_data_in)
  );

  // Drive one cycle at the negedge, predict outputs, advance the model.
  task automatic apply(input bit r, input bit cr, input bit cw,
                       input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input bit er, input bit ew,
                       input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                       input bit lk);
    bit cpu_win, ext_win;
    @(negedge clk);
    cyc++;
    reset_in = r;
    cpu_req_in = cr; cpu_wr_in = cw;
    cpu_address_in = ca; cpu_data_in = cd;
    ext_req_in = er; ext_wr_in = ew;
    ext_address_in = ea; ext_data_in = ed;
    ext_lock_in = lk;
    mem_data_in = DW'($urandom);
    #2;
    if (r) begin
      m_wait = 0; m_locked = 0; m_owner = 0;
    end
    cpu_win = 0; ext_win = 0;
    if (!r) begin
      if (m_locked) ext_win = er;
      else if (cr && (!er || m_wait < LIMIT)) cpu_win = 1;
      else if (er) ext_win = 1;
    end
    exp = {cr && !cpu_win, ext_win, (cpu_win && cw) || (ext_win && ew),
           m_owner == 1, m_owner == 2, ext_win ? ea : ca,
           ext_win ? ed : cd,
           (m_owner == 1) ? mem_data_in : DW'(0),
           (m_owner == 2) ? mem_data_in : DW'(0)};
    if (!r) begin
      m_owner = (cpu_win && !cw) ? 1 : (ext_win && !ew) ? 2 : 0;
      m_wait = (er && cpu_win) ?
               ((m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1) : 0;
`ifdef ARBITER_BURST_LOCK_EN
      m_locked = m_locked ? (er && lk) : (ext_win && lk);
`endif
    end
  endtask

  task automatic test_reset();
    apply(1, 1, 1, 11'h7FF, 16'hFFFF, 1, 1, 11'h123, 16'h5555, 1);
    checks++;
    if ({ext_gnt_out, mem_wr_out, cpu_valid_out, ext_valid_out} !== 4'b0) begin
      fails++;
      $display("FAIL reset_outs got=%b exp=0000",
               {ext_gnt_out, mem_wr_out, cpu_valid_out, ext_valid_out});
    end
    apply(0, 1, 0, 11'h00D, 16'h0, 0, 0, 11'h0, 16'h0, 0);
    checks++;
    if (mem_address_out !== 11'h00D || cpu_stall_out !== 1'b0) begin
      fails++;
      $display("FAIL first_read addr=%h stall=%b exp 00d/0",
               mem_address_out, cpu_stall_out);
    end
    checks++;
    if (obs !== exp) begin
      fails++; $display("FAIL first_read_vec got=%h exp=%h", obs, exp);
    end
    apply(0, 0, 0, 11'h0, 16'h0, 0, 0, 11'h0, 16'h0, 0);
    checks++;
    if (cpu_valid_out !== 1'b1 || cpu_data_out !== mem_data_in) begin
      fails++;
      $display("FAIL first_return valid=%b data=%h exp 1/%h",
               cpu_valid_out, cpu_data_out, mem_data_in);
    end
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 15; i++) begin
      apply(0, 1, 0, AW'($urandom), DW'($urandom),
            1, 0, AW'($urandom), DW'($urandom), 0);
      checks++;
      if (ext_gnt_out !== (i % 5 == 4) || cpu_stall_out !== (i % 5 == 4)) begin
        fails++;
        $display("FAIL starve_pattern i=%0d gnt=%b stall=%b exp=%b",
                 i, ext_gnt_out, cpu_stall_out, i % 5 == 4);
      end
      checks++;
      if (obs !== exp) begin
        fails++; $display("FAIL starve_vec i=%0d got=%h exp=%h", i, obs, exp);
      end
    end
  endtask

  task automatic test_ext_write();
    apply(0, 0, 0, 11'h0, 16'h0, 1, 1, 11'h005, 16'h0ABC, 0);
    checks++;
    if (ext_gnt_out !== 1'b1 || mem_wr_out !== 1'b1 ||
        mem_data_out !== 16'h0ABC || mem_address_out !== 11'h005) begin
      fails++;
      $display("FAIL ext_write gnt=%b wr=%b data=%h addr=%h",
               ext_gnt_out, mem_wr_out, mem_data_out, mem_address_out);
    end
    apply(0, 0, 0, 11'h0, 16'h0, 0, 0, 11'h0, 16'h0, 0);
    checks++;
    if (ext_valid_out !== 1'b0 || cpu_valid_out !== 1'b0) begin
      fails++;
      $display("FAIL ext_write_novalid ext=%b cpu=%b exp 0/0",
               ext_valid_out, cpu_valid_out);
    end
  endtask

  task automatic test_reset_inflight();
    apply(0, 0, 0, 11'h0, 16'h0, 1, 0, 11'h0AA, 16'h0, 0);
    checks++;
    if (obs !== exp) begin
      fails++; $display("FAIL inflight_grant got=%h exp=%h", obs, exp);
    end
    apply(1, 0, 0, 11'h0, 16'h0, 0, 0, 11'h0, 16'h0, 0);
    checks++;
    if (ext_valid_out !== 1'b0 || ext_gnt_out !== 1'b0 ||
        mem_wr_out !== 1'b0 || ext_data_out !== 16'h0) begin
      fails++;
      $display("FAIL inflight_drop valid=%b gnt=%b wr=%b data=%h",
               ext_valid_out, ext_gnt_out, mem_wr_out, ext_data_out);
    end
    apply(0, 0, 0, 11'h0, 16'h0, 0, 0, 11'h0, 16'h0, 0);
  endtask

  task automatic test_alternating();
    for (int i = 0; i < 8; i++) begin
      apply(0, i % 2 == 0, 0, AW'($urandom), DW'($urandom),
            i % 2 == 1, 0, AW'($urandom), DW'($urandom), 0);
      checks++;
      if (obs !== exp) begin
        fails++; $display("FAIL alt_vec i=%0d got=%h exp=%h", i, obs, exp);
      end
      if (i > 0) begin
        checks++;
        if (cpu_valid_out !== (i % 2 == 1) || ext_valid_out !== (i % 2 == 0)) begin
          fails++;
          $display("FAIL alt_pulse i=%0d cpu=%b ext=%b",
                   i, cpu_valid_out, ext_valid_out);
        end
      end
    end
  endtask

  task automatic test_burst_lock();
    int gnts, stalls;
    gnts = 0; stalls = 0;
    apply(0, 0, 0, 11'h0, 16'h0, 1, 0, 11'h010, 16'h0, 1);
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, 11'h020, 16'h0, 1, 0, 11'h011, 16'h0, 1);
      gnts += int'(ext_gnt_out);
      stalls += int'(cpu_stall_out);
      checks++;
      if (obs !== exp) begin
        fails++; $display("FAIL burst_vec i=%0d got=%h exp=%h", i, obs, exp);
      end
    end
    checks++;
`ifdef ARBITER_BURST_LOCK_EN
    if (gnts !== 3 || stalls !== 3) begin
      fails++;
      $display("FAIL burst_counts gnt=%0d stall=%0d exp 3/3", gnts, stalls);
    end
`else
    if (gnts !== 0 || stalls !== 0) begin
      fails++;
      $display("FAIL burst_counts gnt=%0d stall=%0d exp 0/0", gnts, stalls);
    end
`endif
    apply(0, 1, 0, 11'h020, 16'h0, 0, 0, 11'h0, 16'h0, 0);
    checks++;
    if (obs !== exp) begin
      fails++; $display("FAIL burst_drop got=%h exp=%h", obs, exp);
    end
    apply(0, 1, 0, 11'h020, 16'h0, 0, 0, 11'h0, 16'h0, 0);
    checks++;
    if (cpu_stall_out !== 1'b0) begin
      fails++; $display("FAIL burst_release stall=%b exp=0", cpu_stall_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0,
            1'($urandom), AW'($urandom), DW'($urandom),
            $urandom_range(0, 1) == 1, 1'($urandom),
            AW'($urandom), DW'($urandom), $urandom_range(0, 3) != 0);
      checks++;
      if (obs !== exp) begin
        fails++; $display("FAIL random_vec i=%0d got=%h exp=%h", i, obs, exp);
      end
    end
  endtask

  initial begin
    reset_in = 1'b1;
    cpu_req_in = 0; cpu_wr_in = 0; cpu_address_in = '0; cpu_data_in = '0;
    ext_req_in = 0; ext_wr_in = 0; ext_address_in = '0; ext_data_in = '0;
    ext_lock_in = 0; mem_data_in = '0;
    test_reset();
    test_starvation();
    apply(0, 0, 0, 11'h0, 16'h0, 0, 0, 11'h0, 16'h0, 0);
    test_ext_write();
    test_reset_inflight();
    test_alternating();
    test_burst_lock();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
